// File: rtl/read_pointer_empty.sv
// Read-side pointer and empty-flag logic for the async FIFO: owns the binary/Gray read
// pointers and derives empty, almost-empty, level and underflow from the synchronized write pointer.
module read_pointer_empty #(
  parameter int address_size           = 3,
  parameter int almost_empty_threshold = 1
) (
  input  logic                    read_clk,
  input  logic                    read_reset,
  input  logic                    read_increment,
  input  logic [address_size:0]   read_to_write_pointer,
  output logic [address_size-1:0] read_address,
  output logic [address_size:0]   read_pointer,
  output logic                    read_empty,
  output logic                    read_almost_empty,
  output logic [address_size:0]   read_level,
  output logic                    read_underflow
);

  localparam logic [address_size:0] threshold = almost_empty_threshold[address_size:0];

  logic [address_size:0] read_binary;
  logic [address_size:0] binary_next;
  logic [address_size:0] gray_next;
  logic [address_size:0] write_binary;
  logic [address_size:0] level_next;
  logic                  pop;

  always_comb begin
    pop          = read_increment & ~read_empty;
    binary_next  = read_binary + {{address_size{1'b0}}, pop};
    gray_next    = (binary_next >> 1) ^ binary_next;
    write_binary = '0;
    // Gray-to-binary: each bit is the XOR of all Gray bits at or above it
    for (int i = 0; i <= address_size; i++) begin
      write_binary[i] = ^(read_to_write_pointer >> i);
    end
    level_next   = write_binary - binary_next;
  end

  assign read_address = read_binary[address_size-1:0];

  always_ff @(posedge read_clk) begin
    if (read_reset) begin
      read_binary       <= '0;
      read_pointer      <= '0;
      read_empty        <= 1'b1;
      read_almost_empty <= 1'b1;
      read_level        <= '0;
      read_underflow    <= 1'b0;
    end else begin
      read_binary       <= binary_next;
      read_pointer      <= gray_next;
      // Compared against the post-pop pointer so the last pop empties on its own edge
      read_empty        <= (gray_next == read_to_write_pointer);
      read_almost_empty <= (level_next <= threshold);
      read_level        <= level_next;
      read_underflow    <= read_increment & read_empty;
    end
  end

endmodule

// File: tb/tb_read_pointer_empty.sv
// Directed plus constrained-random bench for read_pointer_empty (address_size=3, threshold=1).
module tb_read_pointer_empty;

  logic       read_clk = 1'b0;
  logic       read_reset;
  logic       read_increment;
  logic [3:0] read_to_write_pointer;
  logic [2:0] read_address;
  logic [3:0] read_pointer;
  logic       read_empty;
  logic       read_almost_empty;
  logic [3:0] read_level;
  logic       read_underflow;

  read_pointer_empty #(.address_size(3), .almost_empty_threshold(1)) dut (
    .read_clk              (read_clk),
    .read_reset            (read_reset),
    .read_increment        (read_increment),
    .read_to_write_pointer (read_to_write_pointer),
    .read_address          (read_address),
    .read_pointer          (read_pointer),
    .read_empty            (read_empty),
    .read_almost_empty     (read_almost_empty),
    .read_level            (read_level),
    .read_underflow        (read_underflow)
  );

  always #5 read_clk = ~read_clk;

  typedef struct {
    logic [3:0] ptr;
    logic [2:0] addr;
    logic       empty;
    logic       aempty;
    logic [3:0] level;
    logic       uf;
  } exp_t;

  exp_t scoreboard[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int   m_bin   = 0;
  bit   m_empty = 1'b1;
  int   w_bin   = 0;

  function automatic logic [3:0] to_gray(int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  function automatic int from_gray(logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return int'(b);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, predict the post-edge outputs, then compare after the edge.
  task automatic step(input string tag, input bit rst, input bit inc, input logic [3:0] wp);
    exp_t e;
    int   lvl;
    bit   pop;
    read_reset            = rst;
    read_increment        = inc;
    read_to_write_pointer = wp;
    if (rst) begin
      m_bin    = 0;
      e.empty  = 1'b1;
      e.aempty = 1'b1;
      e.level  = 4'd0;
      e.uf     = 1'b0;
    end else begin
      pop      = inc && !m_empty;
      e.uf     = inc && m_empty;
      m_bin    = (m_bin + (pop ? 1 : 0)) % 16;
      lvl      = (from_gray(wp) - m_bin + 16) % 16;
      e.empty  = (to_gray(m_bin) == wp);
      e.level  = lvl[3:0];
      e.aempty = (lvl <= 1);
    end
    m_empty = e.empty;
    e.ptr   = to_gray(m_bin);
    e.addr  = m_bin[2:0];
    scoreboard.push_back(e);
    @(posedge read_clk);
    #1;
    if (scoreboard.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard underrun observed=0 expected=1", tag);
    end else begin
      e = scoreboard.pop_front();
      chk({tag, ".ptr"},    32'(read_pointer),      32'(e.ptr));
      chk({tag, ".addr"},   32'(read_address),      32'(e.addr));
      chk({tag, ".empty"},  32'(read_empty),        32'(e.empty));
      chk({tag, ".aempty"}, 32'(read_almost_empty), 32'(e.aempty));
      chk({tag, ".level"},  32'(read_level),        32'(e.level));
      chk({tag, ".uf"},     32'(read_underflow),    32'(e.uf));
    end
  endtask

  initial begin
    read_reset            = 1'b1;
    read_increment        = 1'b0;
    read_to_write_pointer = 4'b0011;
    @(posedge read_clk);
    #1;

    // reset
    step("rst0", 1, 0, 4'b0011);
    step("rst1", 1, 0, 4'b0011);
    chk("rst_ptr",   32'(read_pointer),      32'h0);
    chk("rst_empty", 32'(read_empty),        32'h1);
    chk("rst_level", 32'(read_level),        32'h0);
    chk("rst_ae",    32'(read_almost_empty), 32'h1);

    // fill then drain
    step("fill", 0, 0, 4'b0011);
    chk("fill_empty", 32'(read_empty), 32'h0);
    chk("fill_level", 32'(read_level), 32'h2);
    chk("fill_ae",    32'(read_almost_empty), 32'h0);
    step("pop1", 0, 1, 4'b0011);
    chk("pop1_addr", 32'(read_address), 32'h1);
    chk("pop1_ptr",  32'(read_pointer), 32'b0001);
    step("pop2", 0, 1, 4'b0011);
    chk("pop2_addr",  32'(read_address), 32'h2);
    chk("pop2_ptr",   32'(read_pointer), 32'b0011);
    chk("pop2_empty", 32'(read_empty),   32'h1);

    // underflow
    step("uf", 0, 1, 4'b0011);
    chk("uf_pulse", 32'(read_underflow), 32'h1);
    chk("uf_ptr",   32'(read_pointer),   32'b0011);
    step("uf_end", 0, 0, 4'b0011);
    chk("uf_clear", 32'(read_underflow), 32'h0);

    // wrap: write pointer advances one per cycle while popping
    for (int i = 3; i <= 16; i++) step("wrap", 0, 1, to_gray(i % 16));
    chk("wrap_pre_ptr",  32'(read_pointer), 32'b1000);
    chk("wrap_pre_addr", 32'(read_address), 32'h7);
    step("wrap_pop", 0, 1, to_gray(1));
    chk("wrap_ptr",  32'(read_pointer), 32'b0000);
    chk("wrap_addr", 32'(read_address), 32'h0);
    chk("wrap_lvl",  32'(read_level),   32'h1);
    step("wrap_last", 0, 1, to_gray(1));
    chk("wrap_empty", 32'(read_empty), 32'h1);

    // full level
    step("full_rst", 1, 0, 4'b1100);
    step("full", 0, 0, 4'b1100);
    chk("full_level", 32'(read_level), 32'h8);
    chk("full_empty", 32'(read_empty), 32'h0);
    chk("full_ae",    32'(read_almost_empty), 32'h0);
    for (int i = 0; i < 7; i++) step("drain", 0, 1, 4'b1100);
    chk("drain_level", 32'(read_level),        32'h1);
    chk("drain_ae",    32'(read_almost_empty), 32'h1);

    // reset mid-operation at binary 5
    step("mid_rst", 1, 0, 4'b1100);
    step("mid_fill", 0, 0, 4'b1100);
    for (int i = 0; i < 5; i++) step("mid_pop", 0, 1, 4'b1100);
    chk("mid_addr", 32'(read_address), 32'h5);
    step("mid_pulse", 1, 1, 4'b1100);
    chk("mid_ptr",   32'(read_pointer), 32'h0);
    chk("mid_empty", 32'(read_empty),   32'h1);
    step("mid_after", 0, 0, 4'b1100);
    chk("mid_reeval", 32'(read_empty), 32'h0);

    // random traffic with a Gray-adjacent, never-overfilling write pointer
    w_bin = 8;
    for (int i = 0; i < 80; i++) begin
      if (((w_bin - m_bin + 16) % 16) < 8 && $urandom_range(0, 1) == 1) w_bin = (w_bin + 1) % 16;
      step("rand", 0, bit'($urandom_range(0, 1)), to_gray(w_bin));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_pointer_empty.md
# read_pointer_empty

Read-side pointer and empty-flag generator for the asynchronous FIFO. It sits directly downstream of the write-to-read pointer synchronizer and consumes the synchronized Gray write pointer in the read clock domain. It also owns the read binary/Gray pointers, the RAM read address, the empty and almost-empty flags, an occupancy estimate and an underflow pulse. Its Gray read pointer feeds the read-to-write synchronizer and, through it, the write-side full logic.

## Interface

Parameters:
- address_size, 3: RAM address width; FIFO depth = 2^address_size; pointers are address_size+1 bits.
- almost_empty_threshold, 1: read_almost_empty asserts when the level is at or below this value; legal range 0..2^address_size.

Ports:
- read_clk  input  1  read-domain clock; all state updates on its rising edge.
- read_reset  input  1  synchronous, active-high reset, sampled on the rising edge of read_clk.
- read_increment  input  1  pop request for one word this cycle.
- read_to_write_pointer  input  address_size+1  synchronized Gray write pointer from the w2r synchronizer.
- read_address  output  address_size  RAM read address; equals binary pointer bits [address_size-1:0].
- read_pointer  output  address_size+1  registered Gray read pointer, sent to the r2w synchronizer.
- read_empty  output  1  registered empty flag.
- read_almost_empty  output  1  registered level <= almost_empty_threshold.
- read_level  output  address_size+1  registered word count, 0..2^address_size.
- read_underflow  output  1  one-cycle pulse when a pop is requested while empty.

## Operation

- Internal state:
  - read_binary is an (address_size+1)-bit binary counter.
  - read_pointer is its registered Gray code.
- Accepted pop: pop = read_increment & ~read_empty.
- Next-state values:
  - binary_next = read_binary + pop, modulo 2^(address_size+1).
  - gray_next = (binary_next >> 1) ^ binary_next.
- Registered updates each edge:
  - read_binary <= binary_next.
  - read_pointer <= gray_next.
  - read_empty <= (gray_next == read_to_write_pointer).
- Level computation:
  - write_binary = Gray-to-binary of read_to_write_pointer: XOR-prefix from the MSB down.
  - read_level <= (write_binary - binary_next), modulo 2^(address_size+1).
  - read_almost_empty <= (level_next <= almost_empty_threshold).
- read_underflow <= read_increment & read_empty. The pointer does not move on a rejected pop.
- Reset values (read_reset = 1 at an edge), overriding all other updates:
  - read_binary = 0, read_pointer = 0, read_address = 0.
  - read_empty = 1, read_almost_empty = 1, read_level = 0, read_underflow = 0.
- Wrap-around: binary 2^(address_size+1)-1 goes to 0. The MSB distinguishes laps. For address_size=3, Gray 4'b1000 goes to 4'b0000.
- Simultaneous events: when a pop coincides with a change of read_to_write_pointer, empty and level are computed from the post-pop pointer against the current synchronized value.
- An empty flag that is stale-high because of synchronizer delay is conservative and is legal.
- Reset mid-operation: pointers return to 0 regardless of the synchronized write pointer. Empty is forced to 1 and re-evaluated on the first non-reset edge.
- read_to_write_pointer is assumed Gray-adjacent between samples. No check is required.

## Timing

- All outputs are registered; there are no combinational input-to-output paths.
- Pop latency: read_increment sampled high at edge N (not empty) gives a new read_address and read_pointer after edge N.
- The RAM reads the current read_address combinationally before edge N; the data word is valid in the cycle the pop is asserted.
- Empty deassertion: the first edge after the synchronized pointer changes, i.e. write-side pointer update + 2 read_clk synchronizer stages + 1.
- Empty assertion on the last pop: same edge as that pop (edge N).
- read_underflow is high for exactly the cycle after the rejected request.

## Test plan

1. **Reset.** Hold read_reset=1 for 2 cycles with read_to_write_pointer=4'b0011 → read_pointer=0, read_address=0, read_empty=1, read_level=0, read_almost_empty=1, read_underflow=0.
2. **Fill then drain.** Release reset, read_to_write_pointer=4'b0011 (binary 2) → next edge read_empty=0, read_level=2, read_almost_empty=0. Pop 2 cycles → read_address 1 then 2, read_pointer 4'b0001 then 4'b0011, read_empty=1 on the second pop edge.
3. **Underflow.** read_increment=1 while empty → read_pointer unchanged, read_underflow=1 for one cycle, read_empty stays 1.
4. **Wrap.** Advance the synchronized write pointer and pop until binary 15 (Gray 4'b1000, address 7). Next pop → read_pointer 4'b0000, read_address 0. Empty and level stay correct across the wrap.
5. **Full level.** Read pointer at 0, read_to_write_pointer=4'b1100 (binary 8) → read_level=8, read_empty=0, read_almost_empty=0. Pop 7 times → read_level=1, read_almost_empty=1.
6. **Reset mid-operation.** At binary 5 with the FIFO non-empty, pulse read_reset → next edge read_pointer=0 and read_empty=1. The following edge has read_empty=(0 == read_to_write_pointer).
